display_arbiter: RTL and testbench



---
 rtl/display_arbiter.sv | 116 +++++++++++
 tb/tb_display_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/display_arbiter.sv
// Two-requester arbiter for the 8-digit seven-segment driver: picks an owner, enforces a
// minimum hold time in ticks, alternates under contention and registers the owner's digits.
module display_arbiter #(
  parameter int unsigned TICK_DIV   = 25000000,
  parameter int unsigned HOLD_TICKS = 4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        req_a,
  input  logic        req_b,
  input  logic [31:0] data_a,
  input  logic [31:0] data_b,
  output logic        grant_a,
  output logic        grant_b,
  output logic        blank,
  output logic [3:0]  data_7,
  output logic [3:0]  data_6,
  output logic [3:0]  data_5,
  output logic [3:0]  data_4,
  output logic [3:0]  data_3,
  output logic [3:0]  data_2,
  output logic [3:0]  data_1,
  output logic [3:0]  data_0
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HW = $clog2(HOLD_TICKS + 1);
  localparam logic [TW-1:0] TickMax = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HoldMax = HW'(HOLD_TICKS);

  typedef enum logic [1:0] {StIdle, StOwnA, StOwnB} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          last_b_q, last_b_d;
  logic [31:0]   data_q, data_d;
  logic          tick, hold_done, new_grant;

  assign tick      = (tick_q == TickMax);
  assign hold_done = (hold_q == HoldMax);
  assign tick_d    = tick ? '0 : tick_q + 1'b1;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        // On a tie the requester that did not own last wins; reset favours A.
        if (req_a && req_b)  state_d = last_b_q ? StOwnA : StOwnB;
        else if (req_a)      state_d = StOwnA;
        else if (req_b)      state_d = StOwnB;
      end
      StOwnA: begin
        if (!req_a)                   state_d = req_b ? StOwnB : StIdle;
        else if (req_b && hold_done)  state_d = StOwnB;
      end
      StOwnB: begin
        if (!req_b)                   state_d = req_a ? StOwnA : StIdle;
        else if (req_a && hold_done)  state_d = StOwnA;
      end
      default: state_d = StIdle;
    endcase
  end

  assign new_grant = (state_d != state_q) && (state_d != StIdle);

  always_comb begin
    hold_d   = hold_q;
    last_b_d = last_b_q;
    if (new_grant) begin
      hold_d   = '0;
      last_b_d = (state_d == StOwnB);
    end else if (tick && !hold_done) begin
      hold_d = hold_q + 1'b1;
    end
  end

  // Digits follow the next owner so they change in the same cycle as the grant.
  always_comb begin
    data_d = '0;
    unique case (state_d)
      StOwnA:  data_d = data_a;
      StOwnB:  data_d = data_b;
      default: data_d = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      tick_q   <= '0;
      hold_q   <= '0;
      last_b_q <= 1'b1;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      hold_q   <= hold_d;
      last_b_q <= last_b_d;
      data_q   <= data_d;
    end
  end

  assign grant_a = (state_q == StOwnA);
  assign grant_b = (state_q == StOwnB);
  assign blank   = (state_q == StIdle);
  assign data_7  = data_q[31:28];
  assign data_6  = data_q[27:24];
  assign data_5  = data_q[23:20];
  assign data_4  = data_q[19:16];
  assign data_3  = data_q[15:12];
  assign data_2  = data_q[11:8];
  assign data_1  = data_q[7:4];
  assign data_0  = data_q[3:0];

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter: an owner/tick-count model checked every cycle, plus
// hand-computed expectations at the key arbitration points.
module tb_display_arbiter;

  localparam int TICK_DIV = 4;
  localparam int HOLD     = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [31:0] data_a = '0, data_b = '0;
  logic        grant_a, grant_b, blank;
  logic [3:0]  data_7, data_6, data_5, data_4, data_3, data_2, data_1, data_0;
  logic [31:0] digits;

  int vectors = 0;
  int miscompares = 0;

  display_arbiter #(.TICK_DIV(TICK_DIV), .HOLD_TICKS(HOLD)) dut (
    .CLK(clk), .reset(reset), .req_a(req_a), .req_b(req_b),
    .data_a(data_a), .data_b(data_b),
    .grant_a(grant_a), .grant_b(grant_b), .blank(blank),
    .data_7(data_7), .data_6(data_6), .data_5(data_5), .data_4(data_4),
    .data_3(data_3), .data_2(data_2), .data_1(data_1), .data_0(data_0)
  );

  always #5 clk = ~clk;

  assign digits = {data_7, data_6, data_5, data_4, data_3, data_2, data_1, data_0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Model: owner 0=none, 1=A, 2=B; held = whole ticks seen since the grant, capped.
  int          m_owner, m_last, m_held, m_cyc, m_next;
  logic [31:0] m_data;

  function automatic int next_owner(input int owner, input int last, input int held,
                                    input logic ra, input logic rb);
    logic mine, other;
    if (owner == 0) begin
      if (ra && rb) return (last == 2) ? 1 : 2;
      if (ra) return 1;
      if (rb) return 2;
      return 0;
    end
    mine  = (owner == 1) ? ra : rb;
    other = (owner == 1) ? rb : ra;
    if (!mine) return other ? 3 - owner : 0;
    if (other && held >= HOLD) return 3 - owner;
    return owner;
  endfunction

  always_comb m_next = next_owner(m_owner, m_last, m_held, req_a, req_b);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_owner <= 0;
      m_last  <= 2;
      m_held  <= 0;
      m_cyc   <= 0;
      m_data  <= '0;
    end else begin
      m_owner <= m_next;
      m_cyc   <= (m_cyc + 1) % TICK_DIV;
      if (m_next != m_owner && m_next != 0) begin
        m_held <= 0;
        m_last <= m_next;
      end else if (m_cyc == TICK_DIV - 1 && m_held < HOLD) begin
        m_held <= m_held + 1;
      end
      m_data <= (m_next == 1) ? data_a : (m_next == 2) ? data_b : 32'h0;
    end
  end

  always @(negedge clk) begin
    check("model_grant_a", {31'b0, grant_a}, {31'b0, m_owner == 1});
    check("model_grant_b", {31'b0, grant_b}, {31'b0, m_owner == 2});
    check("model_blank", {31'b0, blank}, {31'b0, m_owner == 0});
    check("model_digits", digits, m_data);
    check("mutex", {31'b0, grant_a & grant_b}, 32'h0);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    data_b = 32'h9876FEDC;
    #21 reset = 1'b0;
    // Idle after reset (edges 1..20).
    step(20);
    check("idle_blank", {31'b0, blank}, 32'h1);
    check("idle_digits", digits, 32'h0);
    // A alone.
    req_a = 1'b1; data_a = 32'h12345678;
    step(1);
    check("a_grant", {30'b0, grant_a, grant_b}, 32'h2);
    check("a_digits", digits, 32'h12345678);
    data_a = 32'hABCDEF01;
    step(1);
    check("a_digits_upd", digits, 32'hABCDEF01);
    req_a = 1'b0;
    step(1);
    check("a_release_blank", {31'b0, blank}, 32'h1);

    // Fresh reset, then both request together.
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    req_a = 1'b1; req_b = 1'b1;
    step(1);                       // edge 1
    check("tie_a_first", {30'b0, grant_a, grant_b}, 32'h2);
    step(7);                       // edge 8: hold reaches 2
    check("hold_a_kept", {30'b0, grant_a, grant_b}, 32'h2);
    step(1);                       // edge 9
    check("preempt_to_b", {30'b0, grant_a, grant_b}, 32'h1);
    check("b_digits", digits, 32'h9876FEDC);
    step(8);                       // edge 17
    check("back_to_a", {30'b0, grant_a, grant_b}, 32'h2);

    // A drops before hold_done: immediate switch, no blank.
    step(1);                       // edge 18
    req_a = 1'b0;
    step(1);                       // edge 19
    check("release_to_b", {29'b0, grant_a, grant_b, blank}, 32'h2);

    // A owns alone, B arrives after one tick; preempt after the second tick.
    req_a = 1'b1; req_b = 1'b0;
    step(1);                       // edge 20: A granted, hold 0
    check("a_regrant", {30'b0, grant_a, grant_b}, 32'h2);
    step(4);                       // edge 24: hold 1
    req_b = 1'b1;
    step(4);                       // edge 28: hold 2
    check("a_before_preempt", {30'b0, grant_a, grant_b}, 32'h2);
    step(1);                       // edge 29
    check("b_preempts", {30'b0, grant_a, grant_b}, 32'h1);

    // Mid-hold reset while B owns.
    step(2);                       // edge 31
    reset = 1'b1;
    #1;
    check("async_reset_grants", {29'b0, grant_a, grant_b, blank}, 32'h1);
    check("async_reset_digits", digits, 32'h0);
    step(1);
    reset = 1'b0;
    step(1);
    check("after_reset_a", {30'b0, grant_a, grant_b}, 32'h2);
    req_a = 1'b0; req_b = 1'b0;
    step(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
